rpn_token_sequencer: RTL
========================

Name: rpn_token_sequencer

Overview:
- Initiator for the RPN calculator token interface. Holds a small token program, streams it one token at a time over the calculator's strobe/ack input handshake, then collects the result over the output handshake.
- Sits between a host or loader and the calculator. Program memory is loaded through a simple write port, and a run is started with `start`.

Parameters:
- WIDTH, 32: token and result data width.
- DEPTH, 32: number of program token entries.
- AW, 5: program address width; DEPTH must be ≤ 2**AW.

Ports:
- CLK, input, 1: clock.
- RST, input, 1: reset; asynchronous, active-high.
- load_we, input, 1: program write enable.
- load_addr, input, AW: program write address.
- load_data, input, WIDTH: token value.
- load_is_op, input, 1: token is an operator.
- start, input, 1: start run (sampled in IDLE only).
- len, input, AW+1: number of valid tokens, latched at start.
- busy, output, 1: run in progress.
- done, output, 1: one-cycle pulse at end of run.
- err, output, 1: run ended abnormally; valid with done, held until next start.
- result, output, WIDTH: captured result.
- result_valid, output, 1: result holds the value of the last successful run.
- tok_stb, output, 1: token strobe to calculator.
- tok_data, output, WIDTH: token value.
- tok_is_op, output, 1: operator flag.
- tok_ack, input, 1: token accepted.
- res_stb, input, 1: calculator result valid.
- res_data, input, WIDTH: calculator result.
- res_ack, output, 1: result accepted.

Behaviour:
- Operator encoding (tok_is_op=1): data[2]=1 is '='; otherwise data[1:0] selects 01 '*', 10 '+', 11 '-'.
- Program memory:
  - DEPTH × (WIDTH+1) bits, synchronous write, registered read.
  - Writes are accepted only when busy=0 and ignored otherwise.
  - Contents are not reset.
- Reset: all outputs 0 (tok_data/result 0). State goes to IDLE, pointer 0. Reset mid-run abandons the run immediately, with no done pulse.
- FSM states:
  - IDLE: on start, latch len, set ptr=0, busy=1, clear err, clear result_valid.
    - len=0: go to DONE with err=1.
    - Otherwise go to FETCH.
    - A start while busy is ignored.
  - FETCH: issue read of mem[ptr]; next cycle load tok_data/tok_is_op, assert tok_stb, go to SEND. Total 2 cycles from FETCH entry to tok_stb high.
  - SEND:
    - tok_stb, tok_data and tok_is_op stay constant until tok_ack is sampled high. The calculator reads operator code bits throughout evaluation, so they must not change.
    - On the edge where tok_ack=1: drop tok_stb and increment ptr.
      - If the token was '=': go to WAIT_RES.
      - Else if ptr+1 == len: go to DONE with err=1 (program has no '=').
      - Else go to GAP.
  - GAP: tok_stb low for exactly 1 cycle, then FETCH. Worst case this leaves ≥3 cycles of stb low between tokens.
  - WAIT_RES:
    - res_stb may already be high, since the calculator raises it together with the ack of '='.
    - When res_stb=1: capture res_data into result, go to ACK_RES.
  - ACK_RES: res_ack=1 for exactly 1 cycle, set result_valid=1, go to DONE.
  - DONE: done=1 for 1 cycle, busy=0, go to IDLE.
- A tok_ack or res_stb arriving outside SEND or WAIT_RES is ignored.
- Tokens after '=' in the program are never sent.
- No timeout: a hung calculator keeps busy=1 until RST.
- A back-to-back start in the cycle after done is accepted.

Optional Feature:
- Macro RPN_DEPTH_CHECK_EN.
- When defined:
  - Track a modelled stack depth d (AW+1 bits, cleared at start).
  - A number token sets d+1. '*', '+' and '-' require d≥2 and set d−1. '=' requires d==1.
  - The check runs in FETCH, once the token is loaded and before tok_stb rises.
  - On violation: do not assert tok_stb, set err=1, go to DONE. Tokens already sent are not retracted.
  - A number token when d==DEPTH is also a violation.
- When undefined: no tracking; tokens are sent unconditionally; err arises only from len=0 or a missing '='.

Test Plan:
- Load "3 4 + 5 * =", len=6, start, against the calculator → six tokens in order, result=35, result_valid=1, err=0, done one pulse, res_ack one pulse.
- Load "10 3 - =", len=4, with tok_ack delayed 5 cycles on each token → tok_stb/tok_data stable throughout, result=7.
- Check the inter-token gap: tok_stb falls on the same edge it samples ack and stays low ≥1 cycle. Assert load_we while busy → memory unchanged, verified by a rerun.
- Run with len=0 → done within 2 cycles, err=1, no tok_stb. Load "1 2 +" with len=3 → 3 tokens sent, done, err=1, result_valid=0.
- RST in SEND while holding tok_stb=1 → all outputs 0 on the same edge, no done. A following start runs normally.
- With RPN_DEPTH_CHECK_EN, load "1 + 2 =" → only "1" sent, err=1. Without the macro → "1" and "+" are sent.

Source files
------------

// File: rtl/rpn_token_sequencer.sv
// Streams a stored RPN token program to the calculator over strobe/ack, then collects the result.
// Optional stack-depth checking is compiled in when RPN_DEPTH_CHECK_EN is defined.
module rpn_token_sequencer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load_we,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_is_op,
    input  logic             start,
    input  logic [AW:0]      len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             tok_stb,
    output logic [WIDTH-1:0] tok_data,
    output logic             tok_is_op,
    input  logic             tok_ack,
    input  logic             res_stb,
    input  logic [WIDTH-1:0] res_data,
    output logic             res_ack
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_SEND, S_GAP, S_WAIT_RES, S_ACK_RES, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [AW:0]      ptr_q, ptr_d;
    logic [AW:0]      len_q, len_d;
    logic [WIDTH-1:0] tok_data_q, tok_data_d;
    logic             tok_is_op_q, tok_is_op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             err_q, err_d;
    logic [WIDTH:0]   mem [DEPTH];
    logic [WIDTH:0]   rd_q;
    logic [AW:0]      ptr_inc;
    logic             tok_is_eq;
`ifdef RPN_DEPTH_CHECK_EN
    logic [AW:0]      depth_q, depth_d;
    logic             depth_bad;
`endif

    // Program store: not reset; the read register is sampled every cycle and
    // consumed in S_LOAD, while ptr_q is still the address presented in S_FETCH.
    always_ff @(posedge CLK) begin
        if (load_we && !busy) begin
            mem[load_addr] <= {load_is_op, load_data};
        end
        rd_q <= mem[ptr_q[AW-1:0]];
    end

    assign ptr_inc   = ptr_q + (AW+1)'(1);
    assign tok_is_eq = tok_is_op_q && tok_data_q[2];

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        len_d          = len_q;
        tok_data_d     = tok_data_q;
        tok_is_op_d    = tok_is_op_q;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        err_d          = err_q;
`ifdef RPN_DEPTH_CHECK_EN
        depth_d   = depth_q;
        depth_bad = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d          = len;
                    ptr_d          = '0;
                    err_d          = 1'b0;
                    result_valid_d = 1'b0;
`ifdef RPN_DEPTH_CHECK_EN
                    depth_d = '0;
`endif
                    if (len == '0) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
`ifdef RPN_DEPTH_CHECK_EN
                if (rd_q[WIDTH]) begin
                    if (rd_q[2]) begin
                        depth_bad = (depth_q != (AW+1)'(1));
                    end else begin
                        depth_bad = (depth_q < (AW+1)'(2));
                        depth_d   = depth_q - (AW+1)'(1);
                    end
                end else begin
                    depth_bad = (depth_q >= (AW+1)'(DEPTH));
                    depth_d   = depth_q + (AW+1)'(1);
                end
                if (depth_bad) begin
                    depth_d = depth_q;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tok_data_d  = rd_q[WIDTH-1:0];
                    tok_is_op_d = rd_q[WIDTH];
                    state_d     = S_SEND;
                end
`else
                tok_data_d  = rd_q[WIDTH-1:0];
                tok_is_op_d = rd_q[WIDTH];
                state_d     = S_SEND;
`endif
            end
            S_SEND: begin
                if (tok_ack) begin
                    ptr_d = ptr_inc;
                    if (tok_is_eq) begin
                        state_d = S_WAIT_RES;
                    end else if (ptr_inc == len_q) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: state_d = S_FETCH;
            S_WAIT_RES: begin
                if (res_stb) begin
                    result_d = res_data;
                    state_d  = S_ACK_RES;
                end
            end
            S_ACK_RES: begin
                result_valid_d = 1'b1;
                state_d        = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            len_q          <= '0;
            tok_data_q     <= '0;
            tok_is_op_q    <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
`ifdef RPN_DEPTH_CHECK_EN
            depth_q <= '0;
`endif
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            len_q          <= len_d;
            tok_data_q     <= tok_data_d;
            tok_is_op_q    <= tok_is_op_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
`ifdef RPN_DEPTH_CHECK_EN
            depth_q <= depth_d;
`endif
        end
    end

    // Handshake/status outputs decode from the state register so RST clears them at once.
    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign tok_stb      = (state_q == S_SEND);
    assign res_ack      = (state_q == S_ACK_RES);
    assign tok_data     = tok_data_q;
    assign tok_is_op    = tok_is_op_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign err          = err_q;

endmodule
